au_neg_pipe: RTL and testbench
==============================

AU_NEG_PIPE -- requirements
Module: au_neg_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand word length, >= 1.
REQ-002 SHALL have parameter ARCH, default 0: prefix-AND architecture select, 0 to 2, passed unchanged to the prefix sub-module.
REQ-003 SHALL have parameter STAGES, default 2: number of pipeline register stages, 0 to 8.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: input operand valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts the input this cycle.
REQ-008 SHALL have port in_op, input, 2 bits: operation (0 pass, 1 negate, 2 abs, 3 negative-abs).
REQ-009 SHALL have port in_a, input, WIDTH bits: two's-complement operand.
REQ-010 SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port out_z, output, WIDTH bits: result, modulo 2^WIDTH.
REQ-013 SHALL have port out_ovf, output, 1 bit: true result not representable in WIDTH bits.

Function
REQ-014 Transfer SHALL occur on a port only when valid and ready are both 1 on the same rising edge.
REQ-015 op 0 SHALL give z = a; op 1 SHALL give z = -a; op 2 SHALL give z = a if a[MSB]=0, else -a; op 3 SHALL give z = -a if a[MSB]=0, else a.
REQ-016 Negation SHALL be computed as ~a XOR {prefix-AND of ~a shifted left by one, LSB 1}, i.e. with parallel-prefix propagate lookahead, not a ripple adder.
REQ-017 out_ovf SHALL be 1 only when op is 1, or op is 2 with a[MSB]=1, and a = 1 followed by WIDTH-1 zeros (most negative); out_z SHALL then equal a.
REQ-018 out_ovf SHALL be 0 for op 0 and op 3, and for every other operand.
REQ-019 WIDTH=1 SHALL give z = a for every op, with out_ovf = a for ops 1 and 2.
REQ-020 All arithmetic SHALL be combinational ahead of stage 0; stages 1 to STAGES-1 SHALL be pure delay registers holding z, ovf and a valid bit.
REQ-021 Latency SHALL be STAGES cycles, from input transfer to out_valid, when there is no backpressure.
REQ-022 STAGES=0 SHALL be fully combinational: out_valid=in_valid, in_ready=out_ready.
REQ-023 Stage i SHALL be ready when it is empty or stage i+1 is ready; the last stage's downstream ready SHALL be out_ready.
REQ-024 in_ready SHALL equal stage-0 ready; bubbles SHALL collapse, so a full pipeline holds STAGES results.
REQ-025 Results SHALL leave in acceptance order with no loss and no duplication.
REQ-026 While out_valid=1 and out_ready=0, out_z and out_ovf SHALL hold stable.
REQ-027 Simultaneous input and output transfer on a full pipeline SHALL sustain one result per cycle.

Reset
REQ-028 When rst=1 at a clock edge, all stage valid bits SHALL clear, so out_valid=0 the following cycle; out_z and out_ovf SHALL reset to 0.
REQ-029 An input offered in the same cycle as rst=1 SHALL be discarded; in-flight results SHALL be dropped without being output.
REQ-030 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-031 Op encodings SHALL be localparams in a shared package (au_pkg): OP_PASS=0, OP_NEG=1, OP_ABS=2, OP_NABS=3.
REQ-032 One sub-module SHALL be instantiated: AU_prefix_and (WIDTH, ARCH) for the propagate lookahead.
REQ-033 Pipeline registers SHALL be a generate loop over STAGES; there SHALL be no other state.

Verification (WIDTH=8, STAGES=2 unless noted)
REQ-034 Bench SHALL cover: op1, a=0x05, out_ready=1 -> out_z=0xFB, ovf=0, out_valid exactly 2 cycles after acceptance.
REQ-035 Bench SHALL cover: op1 a=0x80 -> 0x80 ovf=1; op2 a=0xFF -> 0x01 ovf=0; op3 a=0x7F -> 0x81 ovf=0; op3 a=0x80 -> 0x80 ovf=0.
REQ-036 Bench SHALL cover: out_ready=0 for 6 cycles, in_valid=1 continuously -> exactly 2 accepted, in_ready=0 afterwards, out_z stable; on release, results arrive in order, 1/cycle.
REQ-037 Bench SHALL cover: rst=1 for 1 cycle with 2 results in flight -> out_valid=0 next cycle, those results never appear, in_ready=1 after release.
REQ-038 Bench SHALL cover: STAGES=0 and WIDTH=1 builds -> zero latency, in_ready follows out_ready, a=1 op1 -> z=1 ovf=1.
REQ-039 Bench SHALL cover: random streams with random valid/ready, ARCH 0-2 -> compared against a reference model with no mismatch or ordering error.

Source files
------------

// File: rtl/au_pkg.sv
// Shared encodings for the arithmetic-unit negate pipeline: op codes and prefix architectures.
// Pure definitions, no logic; imported by the prefix network and the pipeline top.
package au_pkg;

  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_NEG  = 2'd1;
  localparam logic [1:0] OP_ABS  = 2'd2;
  localparam logic [1:0] OP_NABS = 2'd3;

  localparam int ARCH_RIPPLE   = 0;
  localparam int ARCH_KOGGE    = 1;
  localparam int ARCH_SKLANSKY = 2;

  // Number of doubling levels a log-depth prefix network needs for w bits.
  function automatic int prefix_levels(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/au_prefix_and.sv
// Prefix-AND network, y[i] = &x[i:0]; purely combinational, no latency, no flow control.
// ARCH selects ripple chain (0), Kogge-Stone (1) or Sklansky (2); any other value falls back to ripple.
module AU_prefix_and
  import au_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  if (ARCH == ARCH_KOGGE) begin : g_kogge
    localparam int LEVELS = prefix_levels(WIDTH);
    always_comb begin
      logic [WIDTH-1:0] cur;
      logic [WIDTH-1:0] nxt;
      cur = x;
      nxt = x;
      for (int l = 0; l < LEVELS; l++) begin
        nxt = cur;
        for (int i = 0; i < WIDTH; i++) begin
          if (i >= (1 << l)) nxt[i] = cur[i] & cur[i-(1<<l)];
        end
        cur = nxt;
      end
      y = cur;
    end
  end else if (ARCH == ARCH_SKLANSKY) begin : g_sklansky
    localparam int LEVELS = prefix_levels(WIDTH);
    always_comb begin
      logic [WIDTH-1:0] cur;
      logic [WIDTH-1:0] nxt;
      cur = x;
      nxt = x;
      for (int l = 0; l < LEVELS; l++) begin
        nxt = cur;
        // Upper half of each 2^(l+1) group merges with the top bit of its lower half.
        for (int i = 0; i < WIDTH; i++) begin
          if (((i >> l) & 1) == 1)
            nxt[i] = cur[i] & cur[((i >> (l + 1)) << (l + 1)) + (1 << l) - 1];
        end
        cur = nxt;
      end
      y = cur;
    end
  end else begin : g_ripple
    always_comb begin
      logic [WIDTH-1:0] cur;
      cur = x;
      for (int i = 1; i < WIDTH; i++) begin
        cur[i] = cur[i] & cur[i-1];
      end
      y = cur;
    end
  end

endmodule

// File: rtl/au_neg_pipe.sv
// Pass/negate/abs/negative-abs unit: arithmetic ahead of stage 0, then STAGES valid/ready registers (latency STAGES).
// Backpressure: each stage accepts when empty or its successor accepts, so bubbles collapse; STAGES=0 is combinational.
module au_neg_pipe
  import au_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ARCH   = 0,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_ovf
);

  typedef struct packed {
    logic [WIDTH-1:0] z;
    logic             ovf;
  } res_t;

  logic [WIDTH-1:0] inv_a;
  logic [WIDTH-1:0] inv_sh;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] neg_a;
  logic             most_neg;
  res_t             res;

  assign inv_a = ~in_a;

  // carry[i] = &inv_a[i-1:0]: the +1 of ~a+1 rippling through the low ones of ~a.
  if (WIDTH > 1) begin : g_shift
    assign inv_sh = {inv_a[WIDTH-2:0], 1'b1};
  end else begin : g_shift1
    assign inv_sh = 1'b1;
  end

  AU_prefix_and #(
    .WIDTH(WIDTH),
    .ARCH (ARCH)
  ) u_prefix (
    .x(inv_sh),
    .y(carry)
  );

  assign neg_a = inv_a ^ carry;
  // Only 0 and the most negative value negate to themselves; the sign bit excludes 0.
  assign most_neg = in_a[WIDTH-1] & (neg_a == in_a);

  always_comb begin
    res = '0;
    case (in_op)
      OP_PASS: res.z = in_a;
      OP_NEG: begin
        res.z   = neg_a;
        res.ovf = most_neg;
      end
      OP_ABS: begin
        res.z   = in_a[WIDTH-1] ? neg_a : in_a;
        res.ovf = most_neg;
      end
      default: res.z = in_a[WIDTH-1] ? in_a : neg_a;
    endcase
  end

  if (STAGES == 0) begin : g_comb
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_z     = res.z;
    assign out_ovf   = res.ovf;
  end else begin : g_pipe
    for (genvar i = 0; i < STAGES; i++) begin : g_stg
      logic vld;
      res_t dat;
      logic rdy;
      logic up_vld;
      res_t up_dat;
      logic dn_rdy;

      if (i == 0) begin : g_src
        assign up_vld = in_valid;
        assign up_dat = res;
      end else begin : g_src
        assign up_vld = g_stg[i-1].vld;
        assign up_dat = g_stg[i-1].dat;
      end

      if (i == STAGES - 1) begin : g_dst
        assign dn_rdy = out_ready;
      end else begin : g_dst
        assign dn_rdy = g_stg[i+1].rdy;
      end

      assign rdy = ~vld | dn_rdy;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld <= 1'b0;
          dat <= '0;
        end else if (rdy) begin
          vld <= up_vld;
          if (up_vld) dat <= up_dat;
        end
      end
    end

    assign in_ready  = g_stg[0].rdy;
    assign out_valid = g_stg[STAGES-1].vld;
    assign out_z     = g_stg[STAGES-1].dat.z;
    assign out_ovf   = g_stg[STAGES-1].dat.ovf;
  end

endmodule

// File: tb/tb_au_neg_pipe.sv
// Directed and randomized checks of au_neg_pipe: three ARCH builds at WIDTH=8/STAGES=2 sharing stimulus,
// plus a WIDTH=1/STAGES=0 build exercised combinationally.
module tb_au_neg_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [1:0] in_op;
  logic [7:0] in_a;
  logic [2:0] in_ready_v;
  logic [2:0] out_valid_v;
  logic [2:0] out_ovf_v;
  logic [7:0] out_z_v [3];

  logic       s_valid, s_ready, s_in_ready, s_out_valid, s_ovf;
  logic [1:0] s_op;
  logic [0:0] s_a, s_z;

  au_neg_pipe #(.WIDTH(8), .ARCH(0), .STAGES(2)) u_arch0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]), .in_op(in_op), .in_a(in_a),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_z(out_z_v[0]), .out_ovf(out_ovf_v[0]));
  au_neg_pipe #(.WIDTH(8), .ARCH(1), .STAGES(2)) u_arch1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]), .in_op(in_op), .in_a(in_a),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_z(out_z_v[1]), .out_ovf(out_ovf_v[1]));
  au_neg_pipe #(.WIDTH(8), .ARCH(2), .STAGES(2)) u_arch2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]), .in_op(in_op), .in_a(in_a),
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_z(out_z_v[2]), .out_ovf(out_ovf_v[2]));
  au_neg_pipe #(.WIDTH(1), .ARCH(1), .STAGES(0)) u_w1s0 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_in_ready), .in_op(s_op), .in_a(s_a),
    .out_valid(s_out_valid), .out_ready(s_ready), .out_z(s_z), .out_ovf(s_ovf));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, z} using a plain two's-complement adder.
  function automatic logic [8:0] model(input logic [1:0] op, input logic [7:0] a);
    logic [7:0] n;
    logic       mn;
    n  = ~a + 8'd1;
    mn = (a == 8'h80);
    case (op)
      2'd0:    return {1'b0, a};
      2'd1:    return {mn, n};
      2'd2:    return a[7] ? {mn, n} : {1'b0, a};
      default: return a[7] ? {1'b0, a} : {1'b0, n};
    endcase
  endfunction

  // Called just after a rising edge with out_ready=1; returns just after the result appears.
  task automatic run_vec(input string tag, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] ez, input logic ev);
    int lat;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    @(negedge clk);
    chk({tag, "_acc"}, 32'(in_ready_v[0]), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid_v[0] && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 2);
    chk({tag, "_z"}, 32'(out_z_v[0]), 32'(ez));
    chk({tag, "_ovf"}, 32'(out_ovf_v[0]), 32'(ev));
  endtask

  logic [8:0] exp_mem [3][1024];
  int         acc_n [3];
  int         out_n [3];

  task automatic rnd_sample();
    logic [8:0] got;
    for (int k = 0; k < 3; k++) begin
      if (in_valid && in_ready_v[k]) begin
        exp_mem[k][acc_n[k] & 1023] = model(in_op, in_a);
        acc_n[k]++;
      end
      if (out_valid_v[k] && out_ready) begin
        got = {out_ovf_v[k], out_z_v[k]};
        chk($sformatf("rnd%0d_order_%0d", k, out_n[k]), 32'(out_n[k] < acc_n[k]), 1);
        chk($sformatf("rnd%0d_res_%0d", k, out_n[k]), 32'(got), 32'(exp_mem[k][out_n[k] & 1023]));
        out_n[k]++;
      end
    end
  endtask

  initial begin
    int         acc, outs, seen;
    logic       hs, have, stable;
    logic [7:0] hold;

    rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_a = 8'h00; out_ready = 1'b1;
    s_valid = 1'b0; s_ready = 1'b0; s_op = 2'd0; s_a = 1'b0;
    for (int k = 0; k < 3; k++) begin acc_n[k] = 0; out_n[k] = 0; end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid_v[0]), 0);
    chk("rst_out_z", 32'(out_z_v[0]), 0);
    chk("rst_out_ovf", 32'(out_ovf_v[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready_v[0]), 1);
    @(posedge clk); #1;

    run_vec("neg_05",   2'd1, 8'h05, 8'hFB, 1'b0);
    run_vec("neg_80",   2'd1, 8'h80, 8'h80, 1'b1);
    run_vec("abs_ff",   2'd2, 8'hFF, 8'h01, 1'b0);
    run_vec("nabs_7f",  2'd3, 8'h7F, 8'h81, 1'b0);
    run_vec("nabs_80",  2'd3, 8'h80, 8'h80, 1'b0);
    run_vec("pass_80",  2'd0, 8'h80, 8'h80, 1'b0);
    run_vec("abs_80",   2'd2, 8'h80, 8'h80, 1'b1);
    run_vec("abs_05",   2'd2, 8'h05, 8'h05, 1'b0);
    run_vec("neg_00",   2'd1, 8'h00, 8'h00, 1'b0);
    run_vec("neg_01",   2'd1, 8'h01, 8'hFF, 1'b0);
    run_vec("neg_7f",   2'd1, 8'h7F, 8'h81, 1'b0);
    run_vec("neg_2c",   2'd1, 8'h2C, 8'hD4, 1'b0);
    run_vec("nabs_ff",  2'd3, 8'hFF, 8'hFF, 1'b0);
    run_vec("nabs_00",  2'd3, 8'h00, 8'h00, 1'b0);

    // Backpressure: downstream stalled for 6 cycles with input always offered.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_op = 2'd1; in_a = 8'h10;
    acc = 0; have = 1'b0; stable = 1'b1; hold = 8'h00;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      hs = in_valid && in_ready_v[0];
      if (hs) acc++;
      if (out_valid_v[0]) begin
        if (!have) begin hold = out_z_v[0]; have = 1'b1; end
        else if (out_z_v[0] != hold) stable = 1'b0;
      end
      @(posedge clk); #1;
      if (hs) in_a = in_a + 8'd1;
    end
    chk("bp_accepted", 32'(acc), 2);
    chk("bp_in_ready", 32'(in_ready_v[0]), 0);
    chk("bp_held_value", 32'(hold), 'hF0);
    chk("bp_stable", 32'(stable & have), 1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel0_valid", 32'(out_valid_v[0]), 1);
    chk("bp_rel0_z", 32'(out_z_v[0]), 'hF0);
    @(negedge clk);
    chk("bp_rel1_valid", 32'(out_valid_v[0]), 1);
    chk("bp_rel1_z", 32'(out_z_v[0]), 'hEF);
    @(negedge clk);
    chk("bp_rel2_valid", 32'(out_valid_v[0]), 0);

    // Reset with two results in flight and one offered during reset.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_op = 2'd0; in_a = 8'h33;
    @(posedge clk); #1;
    in_a = 8'h44;
    @(posedge clk); #1;
    chk("rf_full", 32'(in_ready_v[0]), 0);
    rst = 1'b1; in_a = 8'h55;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rf_out_valid", 32'(out_valid_v[0]), 0);
    chk("rf_out_z", 32'(out_z_v[0]), 0);
    chk("rf_in_ready", 32'(in_ready_v[0]), 1);
    out_ready = 1'b1; seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid_v[0]) seen++;
    end
    chk("rf_dropped", 32'(seen), 0);

    // Full throughput: 12 back-to-back inputs, outputs one per cycle.
    @(posedge clk); #1;
    acc = 0; outs = 0; in_op = 2'd1;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 12);
      in_a     = 8'(c);
      @(negedge clk);
      if (in_valid && in_ready_v[0]) acc++;
      if (out_valid_v[0] && out_ready) begin
        chk($sformatf("tp_z_%0d", outs), 32'(out_z_v[0]), 32'(model(2'd1, 8'(outs)) & 9'h0FF));
        outs++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("tp_accepted", 32'(acc), 12);
    chk("tp_delivered", 32'(outs), 12);

    // WIDTH=1, STAGES=0 build: combinational path and ready pass-through.
    s_valid = 1'b1; s_ready = 1'b0; s_op = 2'd1; s_a = 1'b1;
    #1;
    chk("w1_valid", 32'(s_out_valid), 1);
    chk("w1_ready0", 32'(s_in_ready), 0);
    chk("w1_neg_z", 32'(s_z), 1);
    chk("w1_neg_ovf", 32'(s_ovf), 1);
    s_ready = 1'b1; #1;
    chk("w1_ready1", 32'(s_in_ready), 1);
    s_op = 2'd0; #1;
    chk("w1_pass_ovf", 32'(s_ovf), 0);
    s_op = 2'd2; #1;
    chk("w1_abs_z", 32'(s_z), 1);
    chk("w1_abs_ovf", 32'(s_ovf), 1);
    s_op = 2'd3; #1;
    chk("w1_nabs_ovf", 32'(s_ovf), 0);
    s_op = 2'd1; s_a = 1'b0; #1;
    chk("w1_neg0_z", 32'(s_z), 0);
    chk("w1_neg0_ovf", 32'(s_ovf), 0);
    s_valid = 1'b0; #1;
    chk("w1_invalid", 32'(s_out_valid), 0);

    // Random valid/ready streams against all three prefix architectures.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_a      = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom_range(0, 255));
      @(negedge clk);
      rnd_sample();
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      rnd_sample();
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rnd%0d_drained", k), 32'(out_n[k]), 32'(acc_n[k]));
      chk($sformatf("rnd%0d_traffic", k), 32'(acc_n[k] > 100), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
